// File: rtl/fpcvt_pkg.sv
// Shared widths and result payload for the fpcvt magnitude normalizer.
package fpcvt_pkg;
    localparam int unsigned MAG_W   = 11;
    localparam int unsigned EXP_W   = 3;
    localparam int unsigned SIG_W   = 4;
    localparam int unsigned EXP_MAX = 7;
    localparam int unsigned LZ_W    = 4;

    typedef struct packed {
        logic [EXP_W-1:0] exponent;
        logic [SIG_W-1:0] significand;
        logic             fifth_bit;
    } fp_res_t;
endpackage

// File: rtl/lzc11.sv
// 11-bit leading-zero counter built as a priority encoder; all-zero input yields 11.
module lzc11
    import fpcvt_pkg::*;
(
    input  logic [MAG_W-1:0] value_i,
    output logic [LZ_W-1:0]  count_c_o
);

    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        count_c_o = LZ_W'(MAG_W);
        for (int unsigned i = 0; i < MAG_W; i++) begin
            if (value_i[i]) begin
                count_c_o = LZ_W'(MAG_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/convert.sv
// Normalizes an unsigned magnitude into exponent / 4-bit significand / first discarded bit.
module convert
    import fpcvt_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [MAG_W-1:0] magnitude,
    output logic             out_valid,
    output logic [EXP_W-1:0] exponent,
    output logic [SIG_W-1:0] significand,
    output logic             fifth_bit
);

    logic [LZ_W-1:0]  lz_c;
    logic [EXP_W-1:0] exp_c;
    logic [SIG_W:0]   sel_c;
    fp_res_t          res_c;
    fp_res_t          res_d, res_q;
    logic             valid_d, valid_q;

    lzc11 u_lzc (
        .value_i   (magnitude),
        .count_c_o (lz_c)
    );

    // Clamp: values that fit in the significand keep exponent 0.
    always_comb begin
        exp_c = '0;
        if (lz_c <= LZ_W'(EXP_MAX - 1)) begin
            exp_c = EXP_W'(LZ_W'(EXP_MAX) - lz_c);
        end
    end

    // A zero appended below the LSB makes fifth_bit fall out as 0 when exponent is 0.
    always_comb begin
        sel_c                 = (SIG_W + 1)'({magnitude, 1'b0} >> exp_c);
        res_c.exponent    = exp_c;
        res_c.significand = sel_c[SIG_W:1];
        res_c.fifth_bit   = sel_c[0];
    end

    // Data holds across idle cycles; only valid follows in_valid.
    always_comb begin
        valid_d = in_valid;
        res_d   = res_q;
        if (in_valid) begin
            res_d = res_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= '0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
        end
    end

    assign out_valid   = valid_q;
    assign exponent    = res_q.exponent;
    assign significand = res_q.significand;
    assign fifth_bit   = res_q.fifth_bit;

endmodule

// File: tb/tb_convert.sv
// Scoreboard bench for convert: directed spec vectors, exhaustive sweep, random traffic, async reset.
module tb_convert;

    typedef struct packed {
        logic [10:0] mag;
        logic        v;
        logic [2:0]  e;
        logic [3:0]  s;
        logic        f;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [10:0] magnitude;
    logic        out_valid;
    logic [2:0]  exponent;
    logic [3:0]  significand;
    logic        fifth_bit;

    exp_t sb[$];
    exp_t last_res;
    int   checks = 0;
    int   passes = 0;

    convert dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .magnitude   (magnitude),
        .out_valid   (out_valid),
        .exponent    (exponent),
        .significand (significand),
        .fifth_bit   (fifth_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: locate the top set bit, keep the four bits from it downward.
    function automatic exp_t model(input int m);
        exp_t r;
        int   p = -1;
        int   e;
        for (int i = 0; i < 11; i++) if (((m >> i) & 1) == 1) p = i;
        e     = (p > 3) ? p - 3 : 0;
        r.mag = 11'(m);
        r.v   = 1'b1;
        r.e   = 3'(e);
        r.s   = 4'((m >> e) & 15);
        r.f   = (e > 0) ? 1'((m >> (e - 1)) & 1) : 1'b0;
        return r;
    endfunction

    // Drive one cycle; the expectation is queued once the capturing edge has passed.
    task automatic drive(input logic v, input int m, input logic use_k,
                         input int ke, input int ks, input int kf);
        exp_t x;
        in_valid  = v;
        magnitude = 11'(m);
        if (v) begin
            x = model(m);
            if (use_k) begin
                x.e = 3'(ke);
                x.s = 4'(ks);
                x.f = 1'(kf);
            end
            last_res = x;
        end else begin
            x     = last_res;
            x.mag = 11'(m);
            x.v   = 1'b0;
        end
        @(posedge clk);
        sb.push_back(x);
        #1;
    endtask

    // Monitor: compares every presented cycle, and checks the async clear on reset assertion.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                sb.delete();
                checks++;
                if ({out_valid, exponent, significand, fifth_bit} !== 9'b0)
                    $display("FAIL async_reset got v=%0b e=%0d s=%0d f=%0b required all 0",
                             out_valid, exponent, significand, fifth_bit);
                else
                    passes++;
            end else if (sb.size() > 0) begin
                x = sb.pop_front();
                checks++;
                if ({out_valid, exponent, significand, fifth_bit} !== {x.v, x.e, x.s, x.f})
                    $display("FAIL result mag=%0d got v=%0b e=%0d s=%0d f=%0b required v=%0b e=%0d s=%0d f=%0b",
                             x.mag, out_valid, exponent, significand, fifth_bit, x.v, x.e, x.s, x.f);
                else
                    passes++;
            end
        end
    end

    initial begin
        int n;
        last_res  = '0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        magnitude = '0;
        #2 rst_n = 1'b0;
        #10;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Outputs stay at their reset values until the first edge after release.
        drive(1'b0, 0, 1'b0, 0, 0, 0);

        // Directed vectors with spec-given results.
        drive(1'b1, 422,  1'b1, 5, 13, 0);
        drive(1'b1, 2047, 1'b1, 7, 15, 1);
        drive(1'b1, 3,    1'b1, 0, 3,  0);
        drive(1'b1, 15,   1'b1, 0, 15, 0);
        drive(1'b1, 0,    1'b1, 0, 0,  0);
        drive(1'b1, 1024, 1'b1, 7, 8,  0);
        drive(1'b1, 16,   1'b1, 1, 8,  0);
        drive(1'b1, 31,   1'b1, 1, 15, 1);
        drive(1'b1, 422,  1'b1, 5, 13, 0);
        drive(1'b0, 2047, 1'b0, 0, 0,  0);
        drive(1'b0, 5,    1'b0, 0, 0,  0);
        drive(1'b1, 2047, 1'b1, 7, 15, 1);

        // Exhaustive sweep.
        for (int m = 0; m < 2048; m++) drive(1'b1, m, 1'b0, 0, 0, 0);

        // Random traffic with idle gaps and a mid-stream reset.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 2047)), 1'b0, 0, 0, 0);
            if (i == 150) begin
                #2 rst_n = 1'b0;
                last_res = '0;
                @(posedge clk);
                #3 rst_n = 1'b1;
                @(posedge clk);
                #1;
                drive(1'b0, 1234, 1'b0, 0, 0, 0);
            end
        end
        in_valid = 1'b0;

        n = 0;
        while (sb.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            $display("FAIL drain timeout got %0d pending required 0", sb.size());
            $fatal(1, "scoreboard did not drain");
        end
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
